tcb_lib_demultiplexer: RTL and testbench

- Address-decoding demultiplexer sitting directly downstream of the TCB multiplexer/arbiter pair.
- Takes the single arbitrated TCB manager stream and steers each request to one of MPN subordinate ports.
- Tracks the port selection of every accepted transfer for DLY cycles, so each fixed-latency response is returned from the correct subordinate.
- Generates an error response for addresses that match no port.

---
 rtl/tcb_lib_pkg.sv | 45 ++++
 rtl/tcb_lib_decoder.sv | 41 ++++
 rtl/tcb_lib_demultiplexer.sv | 130 +++++++++++++
 tb/tb_tcb_lib_demultiplexer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tcb_lib_pkg.sv
// Shared TCB library types and helpers: demux pipe entry and address decode.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package tcb_lib_pkg;

  // Upper bounds for the generic decode helper; callers zero-extend into these.
  localparam int TCB_ADR_MAX = 64;
  localparam int TCB_MPN_MAX = 16;
  localparam int TCB_MPL_MAX = 4;

  // One slot of the response-tracking pipe.
  typedef struct packed {
    logic                   act;
    logic [TCB_MPL_MAX-1:0] sel;
    logic                   miss;
  } tcb_dmx_ent_t;

  // Decode result: miss flag and winning port index.
  typedef struct packed {
    logic                   miss;
    logic [TCB_MPL_MAX-1:0] sel;
  } tcb_dec_t;

  typedef logic [TCB_MPN_MAX-1:0][TCB_ADR_MAX-1:0] tcb_adr_tbl_t;

  // Lowest matching port wins: scan downward so the last hit is the lowest index.
  function automatic tcb_dec_t tcb_decode(
    input logic [TCB_ADR_MAX-1:0] adr,
    input tcb_adr_tbl_t           dam,
    input tcb_adr_tbl_t           dav,
    input int                     mpn
  );
    tcb_dec_t r;
    r.miss = 1'b1;
    r.sel  = '0;
    for (int i = TCB_MPN_MAX-1; i >= 0; i--) begin
      if ((i < mpn) && ((adr & dam[i]) == dav[i])) begin
        r.miss = 1'b0;
        r.sel  = TCB_MPL_MAX'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tcb_lib_decoder.sv
// Combinational address decoder: address -> {sel, miss} against mask/value table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows adr directly.
module tcb_lib_decoder #(
  parameter int                         ADR = 32,
  parameter int                         MPN = 3,
  parameter int                         SW  = 2,
  parameter logic [MPN-1:0][ADR-1:0]    DAM = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000},
  parameter logic [MPN-1:0][ADR-1:0]    DAV = {32'h0001_0000, 32'h0000_1000, 32'h0000_0000}
)(
  input  logic [ADR-1:0] adr,
  output logic [SW-1:0]  sel,
  output logic           miss
);
  import tcb_lib_pkg::*;

  if (ADR > TCB_ADR_MAX) begin : g_bad_adr
    $error("tcb_lib_decoder: ADR exceeds decode helper width");
  end
  if (MPN > TCB_MPN_MAX) begin : g_bad_mpn
    $error("tcb_lib_decoder: MPN exceeds decode helper port count");
  end

  tcb_adr_tbl_t dam_x;
  tcb_adr_tbl_t dav_x;
  tcb_dec_t     dec;

  // Widen the parameter tables into the helper's fixed-size form and decode.
  always_comb begin
    dam_x = '0;
    dav_x = '0;
    for (int i = 0; i < MPN; i++) begin
      dam_x[i] = TCB_ADR_MAX'(DAM[i]);
      dav_x[i] = TCB_ADR_MAX'(DAV[i]);
    end
    dec  = tcb_decode(TCB_ADR_MAX'(adr), dam_x, dav_x, MPN);
    sel  = SW'(dec.sel);
    miss = dec.miss;
  end

endmodule

// File: rtl/tcb_lib_demultiplexer.sv
// Address-decoding TCB demux: steers one manager stream to MPN subordinates.
// Latency: request path 0 cycles; response returned DLY cycles after transfer.
// Backpressure: s_rdy follows selected port's m_rdy; decode misses always accepted.
module tcb_lib_demultiplexer #(
  parameter int                         ADR = 32,
  parameter int                         DAT = 32,
  parameter int                         UNT = 8,
  parameter int                         BEN = DAT/UNT,
  parameter int                         DLY = 1,
  parameter int                         MPN = 3,
  parameter int                         MPL = $clog2(MPN),
  parameter logic [MPN-1:0][ADR-1:0]    DAM = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000},
  parameter logic [MPN-1:0][ADR-1:0]    DAV = {32'h0001_0000, 32'h0000_1000, 32'h0000_0000},
  parameter int                         ECW = 16
)(
  input  logic                          clk,
  input  logic                          rst,
  // upstream request / response
  input  logic                          s_vld,
  input  logic                          s_wen,
  input  logic [ADR-1:0]                s_adr,
  input  logic [BEN-1:0]                s_ben,
  input  logic [DAT-1:0]                s_wdt,
  output logic                          s_rdy,
  output logic [DAT-1:0]                s_rdt,
  output logic                          s_err,
  // per-port request / response
  output logic [MPN-1:0]                m_vld,
  output logic [MPN-1:0]                m_wen,
  output logic [MPN-1:0][ADR-1:0]       m_adr,
  output logic [MPN-1:0][BEN-1:0]       m_ben,
  output logic [MPN-1:0][DAT-1:0]       m_wdt,
  input  logic [MPN-1:0]                m_rdy,
  input  logic [MPN-1:0][DAT-1:0]       m_rdt,
  input  logic [MPN-1:0]                m_err,
  // decode-error statistics
  output logic [ECW-1:0]                dec_cnt
);
  import tcb_lib_pkg::*;

  // Select width never collapses to zero bits, even for a single port.
  localparam int SW = (MPL > 0) ? MPL : 1;

  if ((DLY < 1) || (DLY > 8)) begin : g_bad_dly
    $error("tcb_lib_demultiplexer: DLY must be in 1..8");
  end
  if (SW > TCB_MPL_MAX) begin : g_bad_mpl
    $error("tcb_lib_demultiplexer: select width exceeds pipe entry field");
  end

  logic [SW-1:0] dec_sel;
  logic          dec_miss;
  logic          xfer;
  tcb_dmx_ent_t  pipe [DLY];
  tcb_dmx_ent_t  tail;
  logic [SW-1:0] tail_sel;

  tcb_lib_decoder #(
    .ADR (ADR),
    .MPN (MPN),
    .SW  (SW),
    .DAM (DAM),
    .DAV (DAV)
  ) u_dec (
    .adr  (s_adr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  // Request payload is broadcast; only m_vld is steered.
  assign m_wen = {MPN{s_wen}};
  assign m_adr = {MPN{s_adr}};
  assign m_ben = {MPN{s_ben}};
  assign m_wdt = {MPN{s_wdt}};

  // Raise valid only on the decoded port, and never while in reset.
  always_comb begin
    m_vld = '0;
    if (s_vld && rst && !dec_miss) begin
      m_vld[dec_sel] = 1'b1;
    end
  end

  // Misses are absorbed locally, so they are always ready.
  assign s_rdy = rst & (dec_miss | m_rdy[dec_sel]);
  assign xfer  = s_vld & s_rdy;

  // Shift the selection of every cycle down the pipe; idle cycles carry act=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DLY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].act  <= xfer;
      pipe[0].sel  <= TCB_MPL_MAX'(dec_sel);
      pipe[0].miss <= dec_miss;
      for (int i = 1; i < DLY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail     = pipe[DLY-1];
  assign tail_sel = SW'(tail.sel);

  // Return the response from the port stored at transfer time, not the current one.
  always_comb begin
    s_rdt = '0;
    s_err = 1'b0;
    if (tail.act) begin
      if (tail.miss) begin
        s_err = 1'b1;
      end else begin
        s_rdt = m_rdt[tail_sel];
        s_err = m_err[tail_sel];
      end
    end
  end

  // Count accepted decode misses, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt <= '0;
    end else if (xfer && dec_miss && (dec_cnt != '1)) begin
      dec_cnt <= dec_cnt + ECW'(1);
    end
  end

endmodule

// File: tb/tb_tcb_lib_demultiplexer.sv
module tb_tcb_lib_demultiplexer;

  logic              clk;
  logic              rst;
  logic              s_vld;
  logic              s_wen;
  logic [31:0]       s_adr;
  logic [3:0]        s_ben;
  logic [31:0]       s_wdt;
  logic [2:0]        m_rdy;
  logic [2:0][31:0]  m_rdt;
  logic [2:0]        m_err;

  // DUT a: DLY=1, DUT b: DLY=3, DUT c: DLY=1 with ECW=2
  logic              s_rdy_a, s_rdy_b, s_rdy_c;
  logic [31:0]       s_rdt_a, s_rdt_b, s_rdt_c;
  logic              s_err_a, s_err_b, s_err_c;
  logic [2:0]        m_vld_a, m_vld_b, m_vld_c;
  logic [2:0]        m_wen_a, m_wen_b, m_wen_c;
  logic [2:0][31:0]  m_adr_a, m_adr_b, m_adr_c;
  logic [2:0][3:0]   m_ben_a, m_ben_b, m_ben_c;
  logic [2:0][31:0]  m_wdt_a, m_wdt_b, m_wdt_c;
  logic [15:0]       dec_cnt_a, dec_cnt_b;
  logic [1:0]        dec_cnt_c;

  int checks;
  int failures;

  tcb_lib_demultiplexer #(.DLY(1)) dut_a (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(s_rdy_a), .s_rdt(s_rdt_a), .s_err(s_err_a),
    .m_vld(m_vld_a), .m_wen(m_wen_a), .m_adr(m_adr_a), .m_ben(m_ben_a), .m_wdt(m_wdt_a),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err), .dec_cnt(dec_cnt_a)
  );

  tcb_lib_demultiplexer #(.DLY(3)) dut_b (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(s_rdy_b), .s_rdt(s_rdt_b), .s_err(s_err_b),
    .m_vld(m_vld_b), .m_wen(m_wen_b), .m_adr(m_adr_b), .m_ben(m_ben_b), .m_wdt(m_wdt_b),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err), .dec_cnt(dec_cnt_b)
  );

  tcb_lib_demultiplexer #(.DLY(1), .ECW(2)) dut_c (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(s_rdy_c), .s_rdt(s_rdt_c), .s_err(s_err_c),
    .m_vld(m_vld_c), .m_wen(m_wen_c), .m_adr(m_adr_c), .m_ben(m_ben_c), .m_wdt(m_wdt_c),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err), .dec_cnt(dec_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    s_vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    s_vld = 1'b1; s_wen = 1'b0; s_adr = 32'h0; s_ben = 4'hF; s_wdt = 32'h0;
    m_rdy = 3'b111; m_rdt = '0; m_err = 3'b000;
    tick(); tick();
    checks++; if (m_vld_a !== 3'b000) begin failures++; $display("FAIL reset_m_vld got=%b exp=000", m_vld_a); end
    checks++; if (s_rdy_a !== 1'b0) begin failures++; $display("FAIL reset_s_rdy got=%b exp=0", s_rdy_a); end
    checks++; if ({s_err_a, s_rdt_a} !== 33'h0) begin failures++; $display("FAIL reset_resp got=%b/%h exp=0/0", s_err_a, s_rdt_a); end
    checks++; if (dec_cnt_a !== 16'd0) begin failures++; $display("FAIL reset_dec_cnt got=%0d exp=0", dec_cnt_a); end
    s_vld = 1'b0;
    #1 rst = 1'b1;
    idle(4);
  endtask

  task automatic test_write();
    s_vld = 1'b1; s_wen = 1'b1; s_adr = 32'h0000_1004; s_wdt = 32'h1312_1110; s_ben = 4'hF;
    m_rdy = 3'b010;
    #1;
    checks++; if (m_vld_a !== 3'b010) begin failures++; $display("FAIL write_m_vld got=%b exp=010", m_vld_a); end
    checks++; if (s_rdy_a !== 1'b1) begin failures++; $display("FAIL write_s_rdy got=%b exp=1", s_rdy_a); end
    checks++; if (m_wdt_a[1] !== 32'h1312_1110 || m_wen_a !== 3'b111) begin failures++; $display("FAIL write_bcast got=%h/%b exp=13121110/111", m_wdt_a[1], m_wen_a); end
    tick();
    s_vld = 1'b0; s_wen = 1'b0;
    #1;
    checks++; if (m_vld_a !== 3'b000) begin failures++; $display("FAIL write_vld_drop got=%b exp=000", m_vld_a); end
    idle(4);
  endtask

  task automatic test_read_dly1();
    m_rdy = 3'b111; m_rdt[0] = 32'h0302_0100;
    s_vld = 1'b1; s_wen = 1'b0; s_adr = 32'h0000_0000;
    tick();
    s_vld = 1'b0;
    checks++; if (s_rdt_a !== 32'h0302_0100 || s_err_a !== 1'b0) begin failures++; $display("FAIL read1_resp got=%h/%b exp=03020100/0", s_rdt_a, s_err_a); end
    tick();
    checks++; if (s_rdt_a !== 32'h0) begin failures++; $display("FAIL read1_after got=%h exp=0", s_rdt_a); end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [3];
    logic [31:0] exp_a [6];
    logic [31:0] exp_b [6];
    adrs  = '{32'h0000_0000, 32'h0000_1000, 32'h0001_0000};
    exp_a = '{32'hA0, 32'hA1, 32'hA2, 32'h0, 32'h0, 32'h0};
    exp_b = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'h0};
    m_rdy = 3'b111;
    m_rdt[0] = 32'hA0; m_rdt[1] = 32'hA1; m_rdt[2] = 32'hA2;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        s_vld = 1'b1; s_wen = 1'b0; s_adr = adrs[k];
      end else begin
        s_vld = 1'b0;
      end
      tick();
      checks++; if (s_rdt_a !== exp_a[k]) begin failures++; $display("FAIL b2b_dly1[%0d] got=%h exp=%h", k, s_rdt_a, exp_a[k]); end
      checks++; if (s_rdt_b !== exp_b[k]) begin failures++; $display("FAIL b2b_dly3[%0d] got=%h exp=%h", k, s_rdt_b, exp_b[k]); end
    end
    idle(4);
  endtask

  task automatic test_miss();
    m_rdy = 3'b000;
    s_vld = 1'b1; s_wen = 1'b0; s_adr = 32'h8000_0000;
    #1;
    checks++; if (s_rdy_a !== 1'b1) begin failures++; $display("FAIL miss_s_rdy got=%b exp=1", s_rdy_a); end
    checks++; if (m_vld_a !== 3'b000) begin failures++; $display("FAIL miss_m_vld got=%b exp=000", m_vld_a); end
    checks++; if (dec_cnt_a !== 16'd0) begin failures++; $display("FAIL miss_cnt_before got=%0d exp=0", dec_cnt_a); end
    tick();
    s_vld = 1'b0;
    checks++; if (s_err_a !== 1'b1 || s_rdt_a !== 32'h0) begin failures++; $display("FAIL miss_resp got=%b/%h exp=1/0", s_err_a, s_rdt_a); end
    checks++; if (dec_cnt_a !== 16'd1) begin failures++; $display("FAIL miss_cnt_one got=%0d exp=1", dec_cnt_a); end
    tick(); tick();
    checks++; if (s_err_b !== 1'b1 || s_rdt_b !== 32'h0) begin failures++; $display("FAIL miss_resp_dly3 got=%b/%h exp=1/0", s_err_b, s_rdt_b); end
    s_vld = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    s_vld = 1'b0;
    checks++; if (dec_cnt_c !== 2'd3) begin failures++; $display("FAIL miss_cnt_sat got=%0d exp=3", dec_cnt_c); end
    checks++; if (dec_cnt_a !== 16'd5) begin failures++; $display("FAIL miss_cnt_five got=%0d exp=5", dec_cnt_a); end
    idle(4);
  endtask

  task automatic test_backpressure();
    m_rdy = 3'b011; m_rdt[2] = 32'hA2;
    s_vld = 1'b1; s_wen = 1'b0; s_adr = 32'h0001_0004;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_rdy_a !== 1'b0 || m_vld_a !== 3'b100) begin failures++; $display("FAIL bp_stall[%0d] got=%b/%b exp=0/100", i, s_rdy_a, m_vld_a); end
      tick();
      checks++; if (s_rdt_a !== 32'h0) begin failures++; $display("FAIL bp_no_resp[%0d] got=%h exp=0", i, s_rdt_a); end
    end
    m_rdy = 3'b111;
    #1;
    checks++; if (s_rdy_a !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", s_rdy_a); end
    tick();
    s_vld = 1'b0;
    checks++; if (s_rdt_a !== 32'hA2) begin failures++; $display("FAIL bp_resp_dly1 got=%h exp=a2", s_rdt_a); end
    tick(); tick();
    checks++; if (s_rdt_b !== 32'hA2) begin failures++; $display("FAIL bp_resp_dly3 got=%h exp=a2", s_rdt_b); end
    idle(4);
  endtask

  task automatic test_reset_mid();
    m_rdy = 3'b111; m_rdt[0] = 32'hA0; m_err = 3'b111;
    s_vld = 1'b1; s_wen = 1'b0; s_adr = 32'h0000_0000;
    tick();
    s_vld = 1'b0;
    tick();
    #1 rst = 1'b0;
    #1;
    checks++; if (s_err_b !== 1'b0 || s_rdt_b !== 32'h0) begin failures++; $display("FAIL rstmid_resp got=%b/%h exp=0/0", s_err_b, s_rdt_b); end
    checks++; if (dec_cnt_b !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", dec_cnt_b); end
    tick();
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (s_err_b !== 1'b0 || s_rdt_b !== 32'h0) begin failures++; $display("FAIL rstmid_post[%0d] got=%b/%h exp=0/0", i, s_err_b, s_rdt_b); end
    end
    m_err = 3'b000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write();
    test_read_dly1();
    test_back_to_back();
    test_miss();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
